// File: rtl/fll_boot_seq.sv
// fll_boot_seq: hardware boot sequencer for the FLL configuration bus.
// On start it writes CFG2/CFG1 of every enabled FLL, polls the status word
// until all enabled FLLs are locked, then writes the clock-mux select word.
// Every bus access uses a 4-phase req/ack handshake guarded by an ack timer.
module fll_boot_seq #(
    parameter int unsigned NR_FLLS      = 4,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned ACK_TIMEOUT  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [NR_FLLS-1:0]    fll_en_i,
    input  logic [DATA_WIDTH-1:0] cfg1_i,
    input  logic [DATA_WIDTH-1:0] cfg2_i,
    input  logic [DATA_WIDTH-1:0] mux_sel_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            err_o,
    output logic [NR_FLLS-1:0]    lock_o,
    output logic                  req_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  web_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    localparam int unsigned IW = $clog2(NR_FLLS + 1);
    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);

    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_MUX    = ADDR_WIDTH'(12);
    localparam logic [IW-1:0]         IDX_NONE = IW'(NR_FLLS);

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_ACK  = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CFG2,
        S_WR_CFG1,
        S_POLL_RD,
        S_POLL_WAIT,
        S_WR_MUX,
        S_DONE
    } state_t;

    // Handshake phase inside a bus-access state:
    // ISSUE waits for ack low then raises req, REQ waits for ack high,
    // REL waits for ack low after req has dropped.
    typedef enum logic [1:0] {
        P_ISSUE,
        P_REQ,
        P_REL
    } phase_t;

    state_t                r_state;
    phase_t                r_phase;
    logic [NR_FLLS-1:0]    r_en;
    logic [DATA_WIDTH-1:0] r_cfg1;
    logic [DATA_WIDTH-1:0] r_cfg2;
    logic [DATA_WIDTH-1:0] r_mux;
    logic [IW-1:0]         r_idx;
    logic [AW-1:0]         r_ack_cnt;
    logic [PW-1:0]         r_poll_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_locked;

    logic [IW-1:0]         w_first;
    logic [IW-1:0]         w_after;
    logic [ADDR_WIDTH-1:0] w_tx_addr;
    logic [DATA_WIDTH-1:0] w_tx_wdata;
    logic                  w_tx_web;
    logic                  w_ack_met;
    logic                  w_ack_expired;
    logic [NR_FLLS-1:0]    w_rd_lock;
    logic                  w_unused_rdata;

    // Lowest enabled FLL index at or above 'from'; IDX_NONE if there is none.
    // Lets disabled FLLs be skipped without spending any cycles on them.
    function automatic logic [IW-1:0] f_next(input logic [NR_FLLS-1:0] en,
                                             input logic [IW-1:0]      from);
        f_next = IDX_NONE;
        for (int unsigned k = 0; k < NR_FLLS; k++) begin
            if (f_next == IDX_NONE && en[k] && k >= 32'(from)) begin
                f_next = IW'(k);
            end
        end
    endfunction

    assign w_first        = f_next(fll_en_i, '0);
    assign w_after        = f_next(r_en, r_idx + IW'(1));
    assign w_rd_lock      = rdata_i[NR_FLLS-1:0] & r_en;
    assign w_ack_met      = (r_phase == P_REQ) ? ack_i : ~ack_i;
    assign w_ack_expired  = (r_ack_cnt == AW'(ACK_TIMEOUT - 1));
    assign w_unused_rdata = ^rdata_i[DATA_WIDTH-1:NR_FLLS];

    // Address, data and direction of the access belonging to the current state
    always_comb begin
        w_tx_addr  = A_STATUS;
        w_tx_wdata = wdata_o;
        w_tx_web   = 1'b1;
        case (r_state)
            S_WR_CFG2: begin
                w_tx_addr  = ADDR_WIDTH'(32'd3 + 32'(r_idx) * 32'd2);
                w_tx_wdata = r_cfg2;
                w_tx_web   = 1'b0;
            end
            S_WR_CFG1: begin
                w_tx_addr  = ADDR_WIDTH'(32'd4 + 32'(r_idx) * 32'd2);
                w_tx_wdata = r_cfg1;
                w_tx_web   = 1'b0;
            end
            S_WR_MUX: begin
                w_tx_addr  = A_MUX;
                w_tx_wdata = r_mux;
                w_tx_web   = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_phase    <= P_ISSUE;
            r_en       <= '0;
            r_cfg1     <= '0;
            r_cfg2     <= '0;
            r_mux      <= '0;
            r_idx      <= '0;
            r_ack_cnt  <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_locked   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= ERR_OK;
            lock_o     <= '0;
            req_o      <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            web_o      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_en       <= fll_en_i;
                        r_cfg1     <= cfg1_i;
                        r_cfg2     <= cfg2_i;
                        r_mux      <= mux_sel_i;
                        r_poll_cnt <= '0;
                        r_ack_cnt  <= '0;
                        r_phase    <= P_ISSUE;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        err_o      <= ERR_OK;
                        if (w_first == IDX_NONE) begin
                            r_state <= S_WR_MUX;
                        end else begin
                            r_idx   <= w_first;
                            r_state <= S_WR_CFG2;
                        end
                    end
                end

                S_POLL_WAIT: begin
                    if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
                        r_state   <= S_POLL_RD;
                        r_phase   <= P_ISSUE;
                        r_ack_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    // One shared ack timer covers every wait of the handshake;
                    // it restarts whenever req rises or falls.
                    if (w_ack_met) begin
                        r_ack_cnt <= '0;
                        case (r_phase)
                            P_ISSUE: begin
                                req_o   <= 1'b1;
                                addr_o  <= w_tx_addr;
                                wdata_o <= w_tx_wdata;
                                web_o   <= w_tx_web;
                                r_phase <= P_REQ;
                            end
                            P_REQ: begin
                                req_o   <= 1'b0;
                                r_phase <= P_REL;
                                if (r_state == S_POLL_RD) begin
                                    lock_o   <= w_rd_lock;
                                    r_locked <= (w_rd_lock == r_en);
                                end
                            end
                            default: begin
                                r_phase <= P_ISSUE;
                                case (r_state)
                                    S_WR_CFG2: r_state <= S_WR_CFG1;
                                    S_WR_CFG1: begin
                                        if (w_after == IDX_NONE) begin
                                            r_state <= S_POLL_RD;
                                        end else begin
                                            r_idx   <= w_after;
                                            r_state <= S_WR_CFG2;
                                        end
                                    end
                                    S_POLL_RD: begin
                                        if (r_locked) begin
                                            r_state <= S_WR_MUX;
                                        end else if (r_poll_cnt == PW'(LOCK_TIMEOUT - 1)) begin
                                            r_poll_cnt <= r_poll_cnt + PW'(1);
                                            err_o      <= ERR_LOCK;
                                            busy_o     <= 1'b0;
                                            done_o     <= 1'b1;
                                            r_state    <= S_DONE;
                                        end else begin
                                            r_poll_cnt <= r_poll_cnt + PW'(1);
                                            r_gap_cnt  <= '0;
                                            r_state    <= S_POLL_WAIT;
                                        end
                                    end
                                    default: begin
                                        busy_o  <= 1'b0;
                                        done_o  <= 1'b1;
                                        r_state <= S_DONE;
                                    end
                                endcase
                            end
                        endcase
                    end else if (w_ack_expired) begin
                        req_o   <= 1'b0;
                        err_o   <= ERR_ACK;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        r_phase <= P_ISSUE;
                        r_state <= S_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + AW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fll_boot_seq.sv
// tb_fll_boot_seq: directed bench for fll_boot_seq with a negedge-driven
// config-bus responder that logs every acknowledged access.
module tb_fll_boot_seq;

    localparam int unsigned POLL_GAP = 4;
    localparam int unsigned LOCK_TO  = 4;
    localparam int unsigned ACK_TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  en = '0;
    logic [31:0] cfg1 = '0, cfg2 = '0, mux = '0;
    logic        busy, done, req, web;
    logic [1:0]  err;
    logic [3:0]  lock, addr;
    logic [31:0] wdata;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic        log_web[$];
    int          rd_cyc[$];
    logic [31:0] stat_q[$];
    int          poll_n = 0;
    int          trans_n = 0;
    int          mute_n = 0;
    int          run_len = 0;
    int          run_max = 0;
    int          cyc = 0;
    logic        prev_req = 1'b0;

    fll_boot_seq #(
        .NR_FLLS(4),
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .POLL_GAP(POLL_GAP),
        .LOCK_TIMEOUT(LOCK_TO),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .fll_en_i(en),
        .cfg1_i(cfg1),
        .cfg2_i(cfg2),
        .mux_sel_i(mux),
        .busy_o(busy),
        .done_o(done),
        .err_o(err),
        .lock_o(lock),
        .req_o(req),
        .addr_o(addr),
        .wdata_o(wdata),
        .web_o(web),
        .ack_i(ack),
        .rdata_i(rdata)
    );

    always #5 clk = ~clk;

    // Responder: raises ack one half-cycle after seeing req, drops it once req
    // is low; transaction number mute_n is never acknowledged.
    always @(negedge clk) begin
        int k;
        cyc = cyc + 1;
        if (req && !prev_req) trans_n = trans_n + 1;
        prev_req = req;
        run_len = req ? run_len + 1 : 0;
        if (run_len > run_max) run_max = run_len;
        if (req && !ack) begin
            if (trans_n != mute_n) begin
                ack = 1'b1;
                log_addr.push_back(addr);
                log_data.push_back(wdata);
                log_web.push_back(web);
                if (web) begin
                    k = (poll_n < stat_q.size()) ? poll_n : stat_q.size() - 1;
                    rdata = stat_q[k];
                    poll_n = poll_n + 1;
                    rd_cyc.push_back(cyc);
                end
            end
        end else if (!req) begin
            ack = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_web.delete();
        rd_cyc.delete();
        poll_n  = 0;
        trans_n = 0;
        run_max = 0;
    endtask

    task automatic chk_entry(input string tag, input int k, input logic [3:0] a,
                             input logic [31:0] d, input logic w);
        if (k >= log_addr.size()) begin
            chk({tag, "_missing"}, 32'(log_addr.size()), 32'(k + 1));
        end else begin
            chk({tag, "_addr"}, 32'(log_addr[k]), 32'(a));
            if (!w) chk({tag, "_data"}, log_data[k], d);
            chk({tag, "_web"}, 32'(log_web[k]), 32'(w));
        end
    endtask

    // Pulses start, scrambles the inputs after capture, waits for done (bounded)
    task automatic run_seq(input logic [3:0] e, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] m);
        int c;
        en = e; cfg1 = c1; cfg2 = c2; mux = m;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(err), 32'd0);
        chk("start_done_clr", 32'(done), 32'd0);
        en = ~e; cfg1 = ~c1; cfg2 = ~c2; mux = ~m;
        c = 0;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_a2[9];
        int c;
        int found;

        // Reset values
        stat_q = '{32'hF};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_web", 32'(web), 32'd1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: all FLLs, locked on first poll
        clear_log();
        stat_q = '{32'hF};
        run_seq(4'b1111, 32'h0025C350, 32'h40060A73, 32'h4321);
        chk("t1_count", 32'(log_addr.size()), 32'd10);
        for (int k = 0; k < 8; k++)
            chk_entry("t1_cfg", k, 4'(3 + k), (k % 2 == 0) ? 32'h40060A73 : 32'h0025C350, 1'b0);
        chk_entry("t1_poll", 8, 4'd0, 32'd0, 1'b1);
        chk_entry("t1_mux", 9, 4'd12, 32'h4321, 1'b0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_lock", 32'(lock), 32'hF);

        // 2: FLLs 0 and 2, lock on the fourth poll
        clear_log();
        stat_q = '{32'h0, 32'h0, 32'h0, 32'h5};
        run_seq(4'b0101, 32'h11, 32'h22, 32'h33);
        exp_a2 = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd12};
        chk("t2_count", 32'(log_addr.size()), 32'd9);
        for (int k = 0; k < 9; k++)
            chk_entry("t2_seq", k, exp_a2[k],
                      (k == 8) ? 32'h33 : ((k % 2 == 0) ? 32'h22 : 32'h11), (k >= 4 && k < 8));
        chk("t2_reads", 32'(rd_cyc.size()), 32'd4);
        for (int k = 1; k < rd_cyc.size(); k++)
            chk("t2_poll_gap", 32'(rd_cyc[k] - rd_cyc[k-1] > int'(POLL_GAP)), 32'd1);
        chk("t2_err", 32'(err), 32'd0);
        chk("t2_lock", 32'(lock), 32'h5);

        // 3: lock never complete -> lock timeout, no mux write
        clear_log();
        stat_q = '{32'h1};
        run_seq(4'b0011, 32'hA1, 32'hA2, 32'hA3);
        chk("t3_count", 32'(log_addr.size()), 32'd8);
        chk("t3_reads", 32'(rd_cyc.size()), 32'd4);
        found = 0;
        foreach (log_addr[k]) if (log_addr[k] == 4'd12) found++;
        chk("t3_no_mux", 32'(found), 32'd0);
        chk("t3_err", 32'(err), 32'd2);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_lock", 32'(lock), 32'h1);

        // 4: second access never acknowledged -> ack timeout, then a clean rerun
        clear_log();
        stat_q = '{32'hF};
        mute_n = 2;
        run_seq(4'b1111, 32'hB1, 32'hB2, 32'hB3);
        chk("t4_count", 32'(log_addr.size()), 32'd1);
        chk("t4_req_len", 32'(run_max), 32'(ACK_TO));
        chk("t4_req_low", 32'(req), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        mute_n = 0;
        clear_log();
        run_seq(4'b1111, 32'hB1, 32'hB2, 32'hB3);
        chk("t4r_count", 32'(log_addr.size()), 32'd10);
        chk_entry("t4r_mux", 9, 4'd12, 32'hB3, 1'b0);
        chk("t4r_err", 32'(err), 32'd0);

        // 5: asynchronous reset while the first CFG1 write has req high
        clear_log();
        en = 4'b1111; cfg1 = 32'hC1; cfg2 = 32'hC2; mux = 32'hC3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c = 0;
        while (!(req && addr == 4'd4) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t5_reached_cfg1", 32'(req && addr == 4'd4), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_req", 32'(req), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_web", 32'(web), 32'd1);
        chk("t5_addr", 32'(addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_resume", 32'(log_addr.size()), 32'd0);
        run_seq(4'b1111, 32'hC1, 32'hC2, 32'hC3);
        chk("t5_count", 32'(log_addr.size()), 32'd10);
        chk_entry("t5_first", 0, 4'd3, 32'hC2, 1'b0);

        // 6: no FLL enabled -> single mux write; start during busy ignored
        clear_log();
        en = 4'b0000; mux = 32'hA5A50001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        en = 4'b1111;
        chk("t6_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c = 2;
        while (!done && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t6_latency_ok", 32'(c <= 4), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("t6_count", 32'(log_addr.size()), 32'd1);
        chk_entry("t6_mux", 0, 4'd12, 32'hA5A50001, 1'b0);
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fll_boot_seq.md
Name: fll_boot_seq

Overview:
Autonomous FLL configuration sequencer that drives the FLL configuration bus (req/ack/addr/wdata/web/rdata) directly, upstream of the FLL macro and in parallel with the APB-to-FLL bridge.
- On a start pulse it programs CFG2 and CFG1 for each enabled FLL, then polls the status register until all enabled FLLs report lock, then writes the clock-mux select register.
- It replaces the manual APB boot sequence with a hardware one, for use when no core runs before the clocks are configured.

Parameters:
NR_FLLS, 4, number of FLLs handled (max 4).
ADDR_WIDTH, 4, FLL config bus word address width.
DATA_WIDTH, 32, FLL config bus data width.
POLL_GAP, 16, idle cycles between consecutive status polls (>=1).
LOCK_TIMEOUT, 1024, maximum number of status polls before lock error (>=1).
ACK_TIMEOUT, 256, maximum cycles waiting for ack rise or fall per transaction (>=2).

Ports:
clk_i  in  1  system clock; FLL config bus is synchronous to it
rst_i  in  1  reset
start_i  in  1  single-cycle start pulse
fll_en_i  in  NR_FLLS  per-FLL enable; captured at start
cfg1_i  in  DATA_WIDTH  CFG1 (MFI/DCO) value for every enabled FLL; captured at start
cfg2_i  in  DATA_WIDTH  CFG2 value for every enabled FLL; captured at start
mux_sel_i  in  DATA_WIDTH  clock-mux select value; captured at start
busy_o  out  1  sequence in progress
done_o  out  1  sequence completed (success or error); level
err_o  out  2  0 = ok, 1 = ack timeout, 2 = lock timeout
lock_o  out  NR_FLLS  last status value read, masked by the captured enables
req_o  out  1  config request
addr_o  out  ADDR_WIDTH  config word address
wdata_o  out  DATA_WIDTH  config write data
web_o  out  1  write enable, active low
ack_i  in  1  config acknowledge
rdata_i  in  DATA_WIDTH  config read data; valid in the cycle ack_i is high

Behaviour:
- One clock domain. Reset is asynchronous and active-high: clk_i, rst_i.
- Reset values: busy_o=0, done_o=0, err_o=0, lock_o=0, req_o=0, addr_o=0, wdata_o=0, web_o=1.
- Address map (word addresses): status=0, bit i = lock of FLL i. FLL i CFG2 = 3+2i, CFG1 = 4+2i. Mux select = 12.
- Handshake, 4-phase:
  - Drive req_o=1 with addr_o/wdata_o/web_o stable until ack_i is sampled high.
  - Next cycle: req_o=0, addr_o/wdata_o held. Wait for ack_i low before the next request may start.
  - Reads capture rdata_i in the cycle ack_i is high.
  - Minimum transaction length is 3 cycles.
- ACK_TIMEOUT counter:
  - Restarts at each req rise and at each req fall.
  - On expiry: req_o=0, err_o=1, go to DONE.
- States and transitions:
  - IDLE --start_i--> capture inputs, busy_o=1, done_o=0, err_o=0, i=0 -> WR_CFG2.
  - WR_CFG2(i) -> WR_CFG1(i) -> next enabled i. Disabled FLLs are skipped with zero cycles spent.
  - After the last FLL -> POLL_RD.
  - POLL_RD: read status; update lock_o = rdata[NR_FLLS-1:0] & en.
    - If (rdata & en) == en -> WR_MUX.
    - Else poll_cnt++. If poll_cnt == LOCK_TIMEOUT -> err_o=2, DONE. Else -> POLL_WAIT.
  - POLL_WAIT: POLL_GAP cycles, then -> POLL_RD.
  - WR_MUX: write mux_sel to address 12 -> DONE.
  - DONE: busy_o=0, done_o=1 (same cycle busy_o falls) -> IDLE. done_o and err_o hold until the next start.
- Boundary cases:
  - fll_en_i=0 at start: no CFG writes, no polls. Issue a single WR_MUX, then done.
  - Lock timeout: the mux write is skipped, so the reference clock stays selected.
  - start_i while busy_o=1: ignored.
  - start_i in the same cycle as DONE: ignored, because IDLE is only entered next cycle.
  - Reset mid-transaction: all outputs revert immediately (asynchronous), req_o drops without waiting for ack, and the sequence is not resumed.
  - ack_i high while idle or unrequested: ignored.
  - Captured inputs are immune to input changes during the run.
- Counters are sized with $clog2(max+1) and saturate at most to the timeout value; no wrap-around.

Test Plan:
1. en=4'b1111, cfg1=0x25C350, cfg2=0x40060A73, mux=0x4321, ack responder with 1-cycle delay, status returns 0xF on the first poll -> exactly 8 writes in order addr 3,4,5,6,7,8,9,10, then read 0, then write 12=0x4321. Then done_o=1, err_o=0, lock_o=0xF.
2. en=4'b0101, status returns 0x0 for 3 polls then 0x5 -> writes only to addr 3,4,7,8. 4 reads spaced by ≥POLL_GAP idle cycles. Mux written. lock_o=0x5.
3. Status stuck at 0x1 with en=4'b0011, LOCK_TIMEOUT=4 -> exactly 4 reads, no write to addr 12, err_o=2, done_o=1, lock_o=0x1.
4. Responder never raises ack on the second transaction -> req_o high for ACK_TIMEOUT cycles then 0, err_o=1, done_o=1. Restart with a good responder -> err_o cleared at start, success.
5. Assert rst_i asynchronously mid-WR_CFG1 with req_o=1 -> req_o=0, busy_o=0, web_o=1 before the next clock edge. start_i after reset release -> full sequence from addr 3.
6. en=0 -> single write 12=mux, done in ≤4 cycles after ack handshake. A start_i pulse during busy -> no second sequence.
